// File: rtl/verilator_bridge_pkg.sv
// Shared types and width helpers for the word-to-byte bridge.
package verilator_bridge_pkg;

  localparam int DEFAULT_NBYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Width of the lane index; one bit minimum so a single-byte word still has a counter.
  function automatic int lane_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

  function automatic int data_width(input int nbytes);
    return 8 * nbytes;
  endfunction

endpackage

// File: rtl/verilator_word_bridge.sv
// Word request to byte-port bridge: serialises one word access into NBYTES
// byte accesses and assembles the read word (pre-write contents on writes).
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | ready for a request; mem_addr holds its last value
// ST_ISSUE | presenting lane lane_q on the byte port
// ST_DRAIN | last lane's read byte arriving on mem_rdata
// ST_RESP  | rsp_valid pulse with the assembled word
module verilator_word_bridge
  import verilator_bridge_pkg::*;
#(
  parameter int NBYTES = DEFAULT_NBYTES
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [8*NBYTES-1:0]   req_wdata,
  input  logic [NBYTES-1:0]     req_wmask,
  output logic                  rsp_valid,
  output logic [8*NBYTES-1:0]   rsp_rdata,
  output logic [31:0]           mem_addr,
  output logic                  mem_wenable,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata
);

  localparam int LANE_W = lane_width(NBYTES);
  localparam int DATA_W = data_width(NBYTES);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NBYTES - 1);
  localparam logic [31:0] LOW_MASK = 32'(NBYTES - 1);

  state_e              state_q, state_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic                wr_q, wr_d;
  logic [NBYTES-1:0]   wmask_q, wmask_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   cap_q, cap_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic                mem_wenable_q, mem_wenable_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic [LANE_W-1:0]   next_lane;
  logic [LANE_W-1:0]   prev_lane;

  assign next_lane = lane_q + 1'b1;
  assign prev_lane = lane_q - 1'b1;

  assign req_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wenable = mem_wenable_q;
  assign mem_wdata   = mem_wdata_q;

  // Next-state logic: lane sequencing, byte-port drive and read-byte capture.
  // The byte read for lane i returns one cycle after it is presented, so while
  // issuing lane i the capture register takes lane i-1; the last lane lands in DRAIN.
  always_comb begin
    state_d       = state_q;
    lane_d        = lane_q;
    wr_d          = wr_q;
    wmask_d       = wmask_q;
    wdata_d       = wdata_q;
    cap_d         = cap_q;
    mem_addr_d    = mem_addr_q;
    mem_wenable_d = 1'b0;
    mem_wdata_d   = mem_wdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d       = ST_ISSUE;
          lane_d        = '0;
          wr_d          = req_write;
          wmask_d       = req_wmask;
          wdata_d       = req_wdata;
          mem_addr_d    = req_addr & ~LOW_MASK;
          mem_wenable_d = req_write & req_wmask[0];
          mem_wdata_d   = req_wdata[7:0];
        end
      end
      ST_ISSUE: begin
        if (lane_q != '0) begin
          cap_d[8*int'(prev_lane) +: 8] = mem_rdata;
        end
        if (lane_q == LAST_LANE) begin
          state_d = ST_DRAIN;
        end else begin
          lane_d        = next_lane;
          mem_addr_d    = mem_addr_q + 32'd1;
          mem_wenable_d = wr_q & wmask_q[next_lane];
          mem_wdata_d   = wdata_q[8*int'(next_lane) +: 8];
        end
      end
      ST_DRAIN: begin
        rsp_rdata_d                = cap_q;
        rsp_rdata_d[DATA_W-1 -: 8] = mem_rdata;
        rsp_valid_d                = 1'b1;
        state_d                    = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any request in flight and clears the byte-port strobe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      lane_q        <= '0;
      wr_q          <= 1'b0;
      wmask_q       <= '0;
      wdata_q       <= '0;
      cap_q         <= '0;
      mem_addr_q    <= '0;
      mem_wenable_q <= 1'b0;
      mem_wdata_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      lane_q        <= lane_d;
      wr_q          <= wr_d;
      wmask_q       <= wmask_d;
      wdata_q       <= wdata_d;
      cap_q         <= cap_d;
      mem_addr_q    <= mem_addr_d;
      mem_wenable_q <= mem_wenable_d;
      mem_wdata_q   <= mem_wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_verilator_word_bridge.sv
// Bench for verilator_word_bridge: byte memory model, word-level reference
// model with a per-cycle compare, and directed scenarios with literal checks.
module tb_verilator_word_bridge;

  localparam int NB = 4;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_addr;
  logic        mem_wenable;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  verilator_word_bridge #(.NBYTES(NB)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_wmask   (req_wmask),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .mem_addr    (mem_addr),
    .mem_wenable (mem_wenable),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Byte memory: addresses folded onto 512 entries (0x100.. and 0xFFFFFFFC.. stay distinct).
  logic       mem_clr;
  logic [7:0] env_mem [0:511];
  always @(posedge clock) begin
    if (mem_clr) begin
      for (int i = 0; i < 512; i++) env_mem[i] <= 8'h00;
      mem_rdata <= 8'h00;
    end else begin
      mem_rdata <= env_mem[mem_addr[8:0]];
      if (mem_wenable) env_mem[mem_addr[8:0]] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state
  logic [7:0]  gold [0:511];
  logic        m_act;
  int          m_acc;
  logic [31:0] m_base;
  logic        m_w;
  logic [31:0] m_wd;
  logic [3:0]  m_wm;
  logic [31:0] m_old;
  logic [31:0] exp_rd;
  logic [31:0] last_addr;
  int          acc_log[$];
  int          rsp_log[$];
  logic [31:0] obs_addr [0:NB-1];
  logic [7:0]  obs_wd [0:NB-1];
  logic [3:0]  obs_we;
  int          obs_rsp_k;

  // Per-cycle compare against the word-level model.
  initial begin
    int          k;
    int          lane;
    logic [31:0] ea;
    logic [31:0] t;
    logic        ewe;
    logic        erv;
    for (int i = 0; i < 512; i++) gold[i] = 8'h00;
    m_act = 1'b0; m_acc = 0; exp_rd = '0; last_addr = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        chk("rst_wenable", {63'd0, mem_wenable}, 64'd0);
        chk("rst_addr", {32'd0, mem_addr}, 64'd0);
        chk("rst_wdata", {56'd0, mem_wdata}, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rdata", {32'd0, rsp_rdata}, 64'd0);
        m_act = 1'b0; exp_rd = '0; last_addr = '0;
      end else begin
        k = cyc - m_acc;
        chk("req_ready", {63'd0, req_ready}, {63'd0, !m_act});
        if (m_act && k >= 1 && k <= NB) begin
          lane = k - 1;
          ea   = m_base + 32'(lane);
          ewe  = m_w && m_wm[lane];
          chk("lane_addr", {32'd0, mem_addr}, {32'd0, ea});
          chk("lane_wenable", {63'd0, mem_wenable}, {63'd0, ewe});
          chk("lane_wdata", {56'd0, mem_wdata}, {56'd0, m_wd[8*lane +: 8]});
          obs_addr[lane] = mem_addr;
          obs_wd[lane]   = mem_wdata;
          obs_we[lane]   = mem_wenable;
          if (ewe) gold[ea[8:0]] = m_wd[8*lane +: 8];
          last_addr = ea;
        end else begin
          chk("idle_wenable", {63'd0, mem_wenable}, 64'd0);
          chk("idle_addr_hold", {32'd0, mem_addr}, {32'd0, last_addr});
        end
        erv = m_act && (k == NB + 2);
        chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, erv});
        if (erv) begin
          exp_rd = m_old;
          m_act = 1'b0;
          obs_rsp_k = k;
        end
        if (rsp_valid) rsp_log.push_back(cyc);
        chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, exp_rd});
        if (req_valid && req_ready) begin
          m_act  = 1'b1;
          m_acc  = cyc;
          m_base = req_addr & ~32'(NB - 1);
          m_w    = req_write;
          m_wd   = req_wdata;
          m_wm   = req_wmask;
          for (int i = 0; i < NB; i++) begin
            t = m_base + 32'(i);
            m_old[8*i +: 8] = gold[t[8:0]];
          end
          acc_log.push_back(cyc);
        end
      end
    end
  end

  // One word request; returns rsp_rdata seen in the response cycle.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, output logic [31:0] r);
    int n;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wmask = m;
    n = 0;
    @(negedge clock);
    while (!req_ready && n < 20) begin n++; @(negedge clock); end
    if (!req_ready) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: got no accept expected accept within 20 cycles");
    end
    @(posedge clock); #1;
    req_valid = 1'b0; req_write = 1'b0;
    n = 0;
    @(negedge clock);
    while (!rsp_valid && n < 20) begin n++; @(negedge clock); end
    if (!rsp_valid) begin
      n_vec++; n_err++;
      $display("FAIL rsp_timeout: got no rsp_valid expected rsp_valid within 20 cycles");
    end
    r = rsp_rdata;
    @(posedge clock); #1;
  endtask

  initial begin
    logic [31:0] r;
    int n0, r0, cnt;
    reset_n = 1'b0; mem_clr = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    repeat (3) @(posedge clock);
    #1 mem_clr = 1'b0;
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    chk("reset_ready", {63'd0, req_ready}, 64'd1);
    chk("reset_rdata", {32'd0, rsp_rdata}, 64'd0);
    chk("reset_addr", {32'd0, mem_addr}, 64'd0);
    @(posedge clock); #1;

    // Full-mask write
    do_req(1'b1, 32'h100, 32'h11223344, 4'hF, r);
    chk("w1_addr0", {32'd0, obs_addr[0]}, 64'h100);
    chk("w1_addr3", {32'd0, obs_addr[3]}, 64'h103);
    chk("w1_wdata", {32'd0, obs_wd[3], obs_wd[2], obs_wd[1], obs_wd[0]}, 64'h11223344);
    chk("w1_we", {60'd0, obs_we}, 64'hF);
    chk("w1_rsp_cycle", 64'(obs_rsp_k), 64'd6);
    chk("w1_old", {32'd0, r}, 64'h0);

    // Unaligned read
    do_req(1'b0, 32'h102, 32'h0, 4'h0, r);
    chk("r1_data", {32'd0, r}, 64'h11223344);
    chk("r1_addr0", {32'd0, obs_addr[0]}, 64'h100);
    chk("r1_we", {60'd0, obs_we}, 64'h0);

    // Partial-mask write returns old word
    do_req(1'b1, 32'h100, 32'hAABBCCDD, 4'h5, r);
    chk("w2_old", {32'd0, r}, 64'h11223344);
    chk("w2_we", {60'd0, obs_we}, 64'h5);
    do_req(1'b0, 32'h100, 32'h0, 4'h0, r);
    chk("r2_data", {32'd0, r}, 64'h11BB33DD);

    // Top-of-address-space read
    do_req(1'b0, 32'hFFFFFFFE, 32'h0, 4'h0, r);
    chk("wrap_addr0", {32'd0, obs_addr[0]}, 64'hFFFFFFFC);
    chk("wrap_addr3", {32'd0, obs_addr[3]}, 64'hFFFFFFFF);
    chk("wrap_data", {32'd0, r}, 64'h0);

    // Reset during cycle 3 of a full write
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h100; req_wdata = 32'h55667788; req_wmask = 4'hF;
    @(negedge clock);
    chk("abort_accept", {63'd0, req_ready}, 64'd1);
    @(posedge clock); #1 req_valid = 1'b0; req_write = 1'b0;
    @(posedge clock);
    @(posedge clock); #2 reset_n = 1'b0;
    #1;
    chk("abort_wenable", {63'd0, mem_wenable}, 64'd0);
    chk("abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("release_ready", {63'd0, req_ready}, 64'd1);
    @(posedge clock); #1;
    do_req(1'b0, 32'h100, 32'h0, 4'h0, r);
    chk("abort_data", {32'd0, r}, 64'h11BB7788);

    // Back-to-back with req_valid held
    n0 = acc_log.size(); r0 = rsp_log.size();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h100;
    cnt = 0;
    while (acc_log.size() < n0 + 3 && cnt < 40) begin @(posedge clock); #1; cnt++; end
    req_valid = 1'b0;
    cnt = 0;
    while (rsp_log.size() < r0 + 3 && cnt < 40) begin @(posedge clock); #1; cnt++; end
    if (acc_log.size() < n0 + 3 || rsp_log.size() < r0 + 3) begin
      n_vec++; n_err++;
      $display("FAIL b2b_timeout: got %0d accepts %0d responses expected 3 each",
               acc_log.size() - n0, rsp_log.size() - r0);
    end else begin
      chk("b2b_acc1", 64'(acc_log[n0+1] - acc_log[n0]), 64'd7);
      chk("b2b_acc2", 64'(acc_log[n0+2] - acc_log[n0]), 64'd14);
      chk("b2b_rsp0", 64'(rsp_log[r0]   - acc_log[n0]), 64'd6);
      chk("b2b_rsp1", 64'(rsp_log[r0+1] - acc_log[n0]), 64'd13);
      chk("b2b_rsp2", 64'(rsp_log[r0+2] - acc_log[n0]), 64'd20);
    end
    repeat (3) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/verilator_word_bridge.md
VERILATOR_WORD_BRIDGE -- requirements
Module: verilator_word_bridge

Interface
REQ-001 SHALL have parameter NBYTES, default 4, meaning bytes per word; legal values 1, 2, 4, 8.
REQ-002 SHALL have one clock and an asynchronous, active-low reset; ports `clock` and `reset_n` are listed first.
REQ-003 clock  in  1  system clock, all state on posedge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 req_valid  in  1  word request present.
REQ-006 req_ready  out  1  bridge accepts request this cycle.
REQ-007 req_write  in  1  1 = masked write, 0 = read.
REQ-008 req_addr  in  32  byte address; low log2(NBYTES) bits ignored.
REQ-009 req_wdata  in  8*NBYTES  write word, little-endian lanes.
REQ-010 req_wmask  in  NBYTES  per-byte write enable.
REQ-011 rsp_valid  out  1  one-cycle response pulse.
REQ-012 rsp_rdata  out  8*NBYTES  word read (old contents on writes).
REQ-013 mem_addr  out  32  byte address to byte memory port.
REQ-014 mem_wenable  out  1  byte write strobe.
REQ-015 mem_wdata  out  8  byte write data.
REQ-016 mem_rdata  in  8  byte read data, valid one cycle after mem_addr presented.

Function
REQ-017 Byte port contract: memory samples mem_addr/mem_wenable/mem_wdata on posedge; mem_rdata reflects that address one cycle later, pre-write contents.
REQ-018 FSM states IDLE, ISSUE, DRAIN, RESP; IDLE -> ISSUE on req_valid && req_ready; ISSUE -> DRAIN after lane NBYTES-1 issued; DRAIN -> RESP; RESP -> IDLE.
REQ-019 req_ready SHALL be 1 only in IDLE; request fields captured on the accept edge.
REQ-020 Base = req_addr with low log2(NBYTES) bits cleared; lane i uses mem_addr = base + i, 32-bit wrap-around.
REQ-021 All mem_* outputs SHALL be registered; lane i presented in cycle 1+i after accept cycle 0.
REQ-022 mem_wenable for lane i SHALL equal req_write && req_wmask[i]; mem_wdata = req_wdata[8i+7:8i]; mem_wenable = 0 outside ISSUE.
REQ-023 Lane i read byte captured at end of cycle 2+i into rsp_rdata[8i+7:8i]; every lane is read regardless of mask.
REQ-024 rsp_valid SHALL be 1 for exactly one cycle, in cycle NBYTES+2 (cycle 6 for NBYTES=4); no response backpressure.
REQ-025 rsp_rdata SHALL hold its value until the next response; writes return pre-write word.
REQ-026 Back-to-back throughput: next accept earliest in cycle NBYTES+3 (one request per 7 cycles at NBYTES=4).
REQ-027 mem_addr SHALL hold its last value while idle (no spurious writes, reads harmless).

Reset
REQ-028 On reset_n low, asynchronously: state IDLE, mem_wenable 0, mem_addr 0, mem_wdata 0, rsp_valid 0, rsp_rdata 0, lane counter 0.
REQ-029 Reset mid-request SHALL abort without response; bytes already written stay written; req_ready 1 in first cycle after release.

Structure
REQ-030 Package verilator_bridge_pkg SHALL hold the FSM state enum and NBYTES-derived constants (lane-index width, data width).
REQ-031 No sub-module; lane counter, capture register and FSM live in one module; a separate top pairs the bridge with the byte memory model for simulation.

Verification
REQ-032 Write 0x11223344 mask 0xF at 0x100 -> mem_addr 0x100..0x103 in cycles 1..4, mem_wdata 44,33,22,11, mem_wenable 1 each, rsp_valid in cycle 6.
REQ-033 Read 0x102 after REQ-032 -> lanes 0x100..0x103 read, rsp_rdata 0x11223344, mem_wenable never 1.
REQ-034 Write 0xAABBCCDD mask 0x5 at 0x100 -> rsp_rdata 0x11223344 (old), subsequent read returns 0x11BB33DD.
REQ-035 Read at 0xFFFFFFFE -> mem_addr 0xFFFFFFFC..0xFFFFFFFF, no carry beyond 32 bits.
REQ-036 Write mask 0xF, reset_n low during cycle 3 -> mem_wenable 0 immediately, no rsp_valid, only bytes 0,1 changed, req_ready 1 after release.
REQ-037 req_valid held high for 3 requests -> accepts in cycles 0, 7, 14, responses in cycles 6, 13, 20.
